obj_fetch_sched: RTL and testbench

OBJ_FETCH_SCHED -- requirements
Module: obj_fetch_sched

---
 rtl/obj_fetch_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_obj_fetch_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obj_fetch_sched.sv
// obj_fetch_sched: per-line OBJ tile fetch scheduler.
//
// Walks the next-list built for the coming scanline. For every valid entry
// and every enabled tile slot k (0..size_x) it fetches two VRAM words (low
// and high bit-plane pairs) and writes one obj_type record into the line
// buffer.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   start                     line-fetch start (restarts when busy)
//   list_count[5:0]           valid next-list entries (0..32)
//   obj_base[14:0]            OBJ tile base word address
//   list_idx[4:0]             next-list read index
//   list_entry[40:0]          entry at list_idx (combinational)
//   vram_req/addr/ack/rdata   VRAM read handshake
//   buf_we, buf_idx, buf_data line-buffer write port (obj_type)
//   busy, done, tile_count, time_over  status
//
// list_entry layout (obj_next_list_type):
//   [40:32] x (signed)  [31:23] tile_index  [22:17] fine_y  [16:14] size_x
//   [13:6] tile_exist   [5] x_flip          [4:2] palette   [1:0] prior
// buf_data layout (obj_type):
//   [45:37] x (signed)  [36:29] pixels_3  [28:21] pixels_2
//   [20:13] pixels_1    [12:5] pixels_0   [4:2] palette     [1:0] prior
//
// Build option: define EPSFC_OBJ_TIME_LIMIT_EN to stop after 34 tiles and
// flag time_over; otherwise the cap is the 64-slot buffer and time_over
// stays 0.

module obj_fetch_sched (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  list_count,
  input  logic [14:0] obj_base,
  output logic [4:0]  list_idx,
  input  logic [40:0] list_entry,
  output logic        vram_req,
  output logic [14:0] vram_addr,
  input  logic        vram_ack,
  input  logic [15:0] vram_rdata,
  output logic        buf_we,
  output logic [5:0]  buf_idx,
  output logic [45:0] buf_data,
  output logic        busy,
  output logic        done,
  output logic [6:0]  tile_count,
  output logic        time_over
);

`ifdef EPSFC_OBJ_TIME_LIMIT_EN
  localparam logic [6:0] TILE_LIMIT = 7'd34;
  localparam logic       LIMIT_FLAG = 1'b1;
`else
  localparam logic [6:0] TILE_LIMIT = 7'd64;
  localparam logic       LIMIT_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, REQ_LO, REQ_HI, WRITE, NEXT, FIN} state_t;

  state_t      state;
  logic [5:0]  ent_idx;
  logic [2:0]  k;
  logic [40:0] entry_q;
  logic [7:0]  pix0;
  logic [7:0]  pix1;

  logic [3:0]  load_slot;
  logic [3:0]  next_slot;
  logic [14:0] load_addr;
  logic [14:0] next_addr;
  logic [14:0] hi_addr;
  logic signed [8:0] slot_x;

  // Lowest enabled slot at or above 'from' within 0..size_x; {found, k}.
  function automatic logic [3:0] find_slot(input logic [7:0] exist,
                                           input logic [2:0] size_x,
                                           input logic [3:0] from);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      if (!r[3] && (4'(i) >= from) && (3'(i) <= size_x) && exist[i])
        r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Word address of the low (hi=0) or high (hi=1) plane pair of slot k.
  // Flip mirrors the tile column, not the screen position.
  function automatic logic [14:0] tile_addr(input logic [40:0] e,
                                            input logic [2:0]  slot,
                                            input logic        hi,
                                            input logic [14:0] base);
    logic [2:0] col;
    logic [8:0] tile;
    col  = e[5] ? (e[16:14] - slot) : slot;
    tile = e[31:23] + {2'b00, e[22:20], 4'b0000} + {6'b000000, col};
    return base + {2'b00, tile, 4'b0000} + {12'b0, e[19:17]} +
           (hi ? 15'd8 : 15'd0);
  endfunction

  assign list_idx = ent_idx[4:0];

  always_comb begin
    load_slot = find_slot(list_entry[13:6], list_entry[16:14], 4'd0);
    next_slot = find_slot(entry_q[13:6], entry_q[16:14], {1'b0, k} + 4'd1);
    load_addr = tile_addr(list_entry, load_slot[2:0], 1'b0, obj_base);
    next_addr = tile_addr(entry_q, next_slot[2:0], 1'b0, obj_base);
    hi_addr   = tile_addr(entry_q, k, 1'b1, obj_base);
    slot_x    = $signed(entry_q[40:32]) + $signed({3'b000, k, 3'b000});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ent_idx    <= 6'd0;
      k          <= 3'd0;
      entry_q    <= 41'd0;
      pix0       <= 8'd0;
      pix1       <= 8'd0;
      vram_req   <= 1'b0;
      vram_addr  <= 15'd0;
      buf_we     <= 1'b0;
      buf_idx    <= 6'd0;
      buf_data   <= 46'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tile_count <= 7'd0;
      time_over  <= 1'b0;
    end else begin
      done   <= 1'b0;
      buf_we <= 1'b0;
      if (start) begin
        // Fresh start or restart: any outstanding request is abandoned.
        if (state != IDLE || start) begin
          state      <= LOAD;
          ent_idx    <= 6'd0;
          k          <= 3'd0;
          tile_count <= 7'd0;
          time_over  <= 1'b0;
          vram_req   <= 1'b0;
          busy       <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            if (ent_idx == list_count) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              entry_q <= list_entry;
              if (!load_slot[3]) begin
                ent_idx <= ent_idx + 6'd1;
              end else if (tile_count == TILE_LIMIT) begin
                time_over <= LIMIT_FLAG;
                state     <= FIN;
                done      <= 1'b1;
              end else begin
                k         <= load_slot[2:0];
                vram_addr <= load_addr;
                vram_req  <= 1'b1;
                state     <= REQ_LO;
              end
            end
          end
          REQ_LO: begin
            if (vram_ack) begin
              pix0      <= vram_rdata[7:0];
              pix1      <= vram_rdata[15:8];
              vram_req  <= 1'b0;
              vram_addr <= hi_addr;
              state     <= REQ_HI;
            end
          end
          REQ_HI: begin
            // First cycle here is the request-low gap after the low ack.
            if (!vram_req) begin
              vram_req <= 1'b1;
            end else if (vram_ack) begin
              vram_req <= 1'b0;
              buf_we   <= 1'b1;
              buf_idx  <= tile_count[5:0];
              buf_data <= {slot_x, vram_rdata[15:8], vram_rdata[7:0],
                           pix1, pix0, entry_q[4:0]};
              state    <= WRITE;
            end
          end
          WRITE: begin
            tile_count <= tile_count + 7'd1;
            state      <= NEXT;
          end
          NEXT: begin
            if (next_slot[3]) begin
              if (tile_count == TILE_LIMIT) begin
                time_over <= LIMIT_FLAG;
                state     <= FIN;
                done      <= 1'b1;
              end else begin
                k         <= next_slot[2:0];
                vram_addr <= next_addr;
                vram_req  <= 1'b1;
                state     <= REQ_LO;
              end
            end else begin
              ent_idx <= ent_idx + 6'd1;
              state   <= LOAD;
            end
          end
          FIN: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_obj_fetch_sched.sv
module tb_obj_fetch_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  list_count = 6'd0;
  logic [14:0] obj_base = 15'd0;
  logic [4:0]  list_idx;
  logic [40:0] list_entry;
  logic        vram_req;
  logic [14:0] vram_addr;
  logic        vram_ack;
  logic [15:0] vram_rdata;
  logic        buf_we;
  logic [5:0]  buf_idx;
  logic [45:0] buf_data;
  logic        busy;
  logic        done;
  logic [6:0]  tile_count;
  logic        time_over;

  logic [40:0] list_mem [32];

  int checks = 0;
  int errors = 0;
  int ack_delay = 1;

  // Monitor records (written only by the monitor process).
  int          n_we = 0;
  int          n_acc = 0;
  int          n_done = 0;
  int          addr_moves = 0;
  logic [14:0] acc_addr [512];
  logic [45:0] we_data [512];
  logic [5:0]  we_idx [512];
  int          we_acc [512];

  obj_fetch_sched dut (
    .clk(clk), .reset_n(reset_n), .start(start), .list_count(list_count),
    .obj_base(obj_base), .list_idx(list_idx), .list_entry(list_entry),
    .vram_req(vram_req), .vram_addr(vram_addr), .vram_ack(vram_ack),
    .vram_rdata(vram_rdata), .buf_we(buf_we), .buf_idx(buf_idx),
    .buf_data(buf_data), .busy(busy), .done(done),
    .tile_count(tile_count), .time_over(time_over)
  );

  always #5 clk = ~clk;

  assign list_entry = list_mem[list_idx];

  function automatic logic [40:0] mk_entry(input logic [8:0] x, input logic [8:0] ti,
                                           input logic [5:0] fy, input logic [2:0] sx,
                                           input logic [7:0] ex, input logic fl,
                                           input logic [2:0] pal, input logic [1:0] pri);
    return {x, ti, fy, sx, ex, fl, pal, pri};
  endfunction

  function automatic logic [45:0] mk_obj(input logic [8:0] x, input logic [7:0] p3,
                                         input logic [7:0] p2, input logic [7:0] p1,
                                         input logic [7:0] p0, input logic [2:0] pal,
                                         input logic [1:0] pri);
    return {x, p3, p2, p1, p0, pal, pri};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // VRAM responder: ack ack_delay+1 edges after the request is seen.
  initial begin
    int rcnt;
    rcnt = 0;
    vram_ack = 1'b0;
    vram_rdata = 16'd0;
    forever begin
      @(posedge clk);
      #2;
      if (vram_req) begin
        if (rcnt >= ack_delay) begin
          vram_ack = 1'b1;
          vram_rdata = {~vram_addr[7:0], vram_addr[7:0]};
          rcnt = 0;
        end else begin
          vram_ack = 1'b0;
          rcnt++;
        end
      end else begin
        vram_ack = 1'b0;
        rcnt = 0;
      end
    end
  end

  // Monitor, sampling on the falling edge.
  initial begin
    logic        pend;
    logic [14:0] paddr;
    pend = 1'b0;
    paddr = 15'd0;
    forever begin
      @(negedge clk);
      if (buf_we) begin
        if (n_we < 512) begin
          we_data[n_we] = buf_data;
          we_idx[n_we] = buf_idx;
          we_acc[n_we] = n_acc;
        end
        n_we++;
      end
      if (vram_req && vram_ack) begin
        if (n_acc < 512) acc_addr[n_acc] = vram_addr;
        n_acc++;
      end
      if (vram_req && pend && (vram_addr !== paddr)) addr_moves++;
      pend = vram_req && !vram_ack;
      paddr = vram_addr;
      if (done) n_done++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges from the one that sampled start until done is seen.
  task automatic wait_done(input string tag, input int max, output int cyc);
    bit ok;
    ok = 1'b0;
    cyc = 1;
    if (done) ok = 1'b1;
    while (!ok && cyc < max) begin
      @(negedge clk);
      cyc++;
      if (done) ok = 1'b1;
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    int cyc;
    int b_we, b_acc, b_done, b_mov;
    int exp_n;
    logic exp_to;

    for (int i = 0; i < 32; i++) list_mem[i] = 41'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_req", 64'(vram_req), 64'd0);
    chk("rst_we", 64'(buf_we), 64'd0);
    chk("rst_addr", 64'(vram_addr), 64'd0);
    chk("rst_bufdata", 64'(buf_data), 64'd0);
    chk("rst_tc", 64'(tile_count), 64'd0);
    chk("rst_lidx", 64'(list_idx), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Empty list
    list_count = 6'd0;
    b_we = n_we; b_acc = n_acc;
    pulse_start();
    chk("empty_busy", 64'(busy), 64'd1);
    wait_done("empty_done_seen", 20, cyc);
    chk("empty_done_lat", 64'(cyc), 64'd2);
    chk("empty_tc", 64'(tile_count), 64'd0);
    @(negedge clk);
    chk("empty_idle_busy", 64'(busy), 64'd0);
    chk("empty_idle_done", 64'(done), 64'd0);
    chk("empty_no_acc", 64'(n_acc - b_acc), 64'd0);
    chk("empty_no_we", 64'(n_we - b_we), 64'd0);

    // One entry, two slots, no flip
    list_mem[0] = mk_entry(9'd10, 9'h005, 6'h0B, 3'd1, 8'h03, 1'b0, 3'd5, 2'd2);
    list_count = 6'd1;
    b_we = n_we; b_acc = n_acc;
    pulse_start();
    wait_done("b_done_seen", 200, cyc);
    chk("b_nacc", 64'(n_acc - b_acc), 64'd4);
    chk("b_addr0", 64'(acc_addr[b_acc]), 64'h0153);
    chk("b_addr1", 64'(acc_addr[b_acc + 1]), 64'h015B);
    chk("b_addr2", 64'(acc_addr[b_acc + 2]), 64'h0163);
    chk("b_addr3", 64'(acc_addr[b_acc + 3]), 64'h016B);
    chk("b_nwe", 64'(n_we - b_we), 64'd2);
    chk("b_idx0", 64'(we_idx[b_we]), 64'd0);
    chk("b_idx1", 64'(we_idx[b_we + 1]), 64'd1);
    chk("b_data0", 64'(we_data[b_we]), 64'(mk_obj(9'd10, 8'hA4, 8'h5B, 8'hAC, 8'h53, 3'd5, 2'd2)));
    chk("b_data1", 64'(we_data[b_we + 1]), 64'(mk_obj(9'd18, 8'h94, 8'h6B, 8'h9C, 8'h63, 3'd5, 2'd2)));
    chk("b_tc", 64'(tile_count), 64'd2);
    chk("b_to", 64'(time_over), 64'd0);
    repeat (3) @(negedge clk);
    chk("b_tc_hold", 64'(tile_count), 64'd2);

    // Flip, negative x, base address wrap
    list_mem[0] = mk_entry(9'h1FC, 9'h005, 6'h0B, 3'd1, 8'h03, 1'b1, 3'd5, 2'd2);
    obj_base = 15'h7F00;
    b_we = n_we; b_acc = n_acc;
    pulse_start();
    wait_done("c_done_seen", 200, cyc);
    chk("c_addr0", 64'(acc_addr[b_acc]), 64'h0063);
    chk("c_addr1", 64'(acc_addr[b_acc + 1]), 64'h006B);
    chk("c_addr2", 64'(acc_addr[b_acc + 2]), 64'h0053);
    chk("c_addr3", 64'(acc_addr[b_acc + 3]), 64'h005B);
    chk("c_data0", 64'(we_data[b_we]), 64'(mk_obj(9'h1FC, 8'h94, 8'h6B, 8'h9C, 8'h63, 3'd5, 2'd2)));
    chk("c_data1", 64'(we_data[b_we + 1]), 64'(mk_obj(9'h004, 8'hA4, 8'h5B, 8'hAC, 8'h53, 3'd5, 2'd2)));
    obj_base = 15'd0;

    // Empty entry skipped, slot gaps, bits past size_x ignored, tile wrap
    list_mem[0] = mk_entry(9'd50, 9'h010, 6'h00, 3'd3, 8'h00, 1'b0, 3'd0, 2'd0);
    list_mem[1] = mk_entry(9'd0, 9'h1FF, 6'h00, 3'd2, 8'h0D, 1'b0, 3'd1, 2'd3);
    list_count = 6'd2;
    b_we = n_we; b_acc = n_acc;
    pulse_start();
    wait_done("g_done_seen", 200, cyc);
    chk("g_nacc", 64'(n_acc - b_acc), 64'd4);
    chk("g_addr0", 64'(acc_addr[b_acc]), 64'h1FF0);
    chk("g_addr1", 64'(acc_addr[b_acc + 1]), 64'h1FF8);
    chk("g_addr2", 64'(acc_addr[b_acc + 2]), 64'h0010);
    chk("g_addr3", 64'(acc_addr[b_acc + 3]), 64'h0018);
    chk("g_x1", 64'(we_data[b_we + 1][45:37]), 64'd16);
    chk("g_tc", 64'(tile_count), 64'd2);

    // Full list: 32 entries x 2 tiles
    for (int i = 0; i < 32; i++)
      list_mem[i] = mk_entry(9'd0, 9'd0, 6'd0, 3'd1, 8'h03, 1'b0, 3'd0, 2'd0);
    list_count = 6'd32;
`ifdef EPSFC_OBJ_TIME_LIMIT_EN
    exp_n = 34;
    exp_to = 1'b1;
`else
    exp_n = 64;
    exp_to = 1'b0;
`endif
    b_we = n_we;
    pulse_start();
    wait_done("d_done_seen", 3000, cyc);
    chk("d_nwe", 64'(n_we - b_we), 64'(exp_n));
    chk("d_tc", 64'(tile_count), 64'(exp_n));
    chk("d_to", 64'(time_over), 64'(exp_to));
    chk("d_last_idx", 64'(we_idx[n_we - 1]), 64'(exp_n - 1));

    // Slow VRAM: address held, no write before both acks
    list_mem[0] = mk_entry(9'd10, 9'h005, 6'h0B, 3'd1, 8'h03, 1'b0, 3'd5, 2'd2);
    list_count = 6'd1;
    ack_delay = 5;
    b_we = n_we; b_acc = n_acc; b_mov = addr_moves;
    pulse_start();
    wait_done("e_done_seen", 300, cyc);
    chk("e_addr_stable", 64'(addr_moves - b_mov), 64'd0);
    chk("e_nwe", 64'(n_we - b_we), 64'd2);
    chk("e_acks_before_we", 64'(we_acc[b_we] - b_acc), 64'd2);
    chk("e_to", 64'(time_over), 64'd0);

    // Restart while the high-plane request is outstanding
    b_we = n_we; b_acc = n_acc;
    pulse_start();
    cyc = 0;
    while ((n_acc - b_acc) < 1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("r_lo_acked", 64'(n_acc - b_acc), 64'd1);
    repeat (2) @(negedge clk);
    chk("r_hi_req", 64'(vram_req), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("r_req_drop", 64'(vram_req), 64'd0);
    chk("r_busy", 64'(busy), 64'd1);
    chk("r_tc0", 64'(tile_count), 64'd0);
    chk("r_lidx0", 64'(list_idx), 64'd0);
    wait_done("r_done_seen", 300, cyc);
    chk("r_nwe", 64'(n_we - b_we), 64'd2);
    chk("r_idx0", 64'(we_idx[b_we]), 64'd0);
    chk("r_addr_after", 64'(acc_addr[b_acc + 1]), 64'h0153);
    chk("r_tc", 64'(tile_count), 64'd2);

    // Reset while the low-plane request is outstanding
    b_we = n_we; b_done = n_done;
    pulse_start();
    cyc = 0;
    while (!vram_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("f_req_up", 64'(vram_req), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("f_req_async", 64'(vram_req), 64'd0);
    chk("f_busy_async", 64'(busy), 64'd0);
    chk("f_tc_async", 64'(tile_count), 64'd0);
    #2;
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("f_no_done", 64'(n_done - b_done), 64'd0);
    chk("f_no_we", 64'(n_we - b_we), 64'd0);
    chk("f_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
